// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
// Imported by the storage top and the dump sequencer.
package register_file_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam bit DEF_ZERO_R0    = 1'b0;
    localparam bit DEF_BYPASS     = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } dump_state_t;

endpackage

// File: rtl/register_file_dump_fsm.sv
// Dump sequencer: walks every register address once per request,
// advancing on valid/ready and pulsing done after the last word.
module register_file_dump_fsm
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ready,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    dump_state_t           state;
    dump_state_t           state_n;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_n;
    logic                  done_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                if (ready) begin
                    if (idx == LAST) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            done  <= done_n;
        end
    end

    assign valid = (state == SCAN);
    assign addr  = idx;

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two combinational read
// ports and a handshaked dump stream sharing the same read path.
module register_file_param
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_R0    = DEF_ZERO_R0,
    parameter bit BYPASS     = DEF_BYPASS
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-1:0] DA,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [ADDR_WIDTH-1:0] AA,
    input  logic [ADDR_WIDTH-1:0] BA,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    input  logic                  Dump_start,
    input  logic                  Dump_ready,
    output logic                  Dump_valid,
    output logic [ADDR_WIDTH-1:0] Dump_addr,
    output logic [DATA_WIDTH-1:0] Dump_data,
    output logic                  Dump_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] raddr [3];
    logic [DATA_WIDTH-1:0] rdata [3];

    // A write aimed at a hard-wired zero register never lands.
    assign wr_ok = WR && !(ZERO_R0 && (DA == '0));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[DA] <= D;
        end
    end

    assign raddr[0] = AA;
    assign raddr[1] = BA;
    assign raddr[2] = Dump_addr;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = regs[raddr[p]];
            if (BYPASS && wr_ok && (raddr[p] == DA)) begin
                rdata[p] = D;
            end
            if (ZERO_R0 && (raddr[p] == '0)) begin
                rdata[p] = '0;
            end
        end
    end

    assign A         = rdata[0];
    assign B         = rdata[1];
    assign Dump_data = rdata[2];

    register_file_dump_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump (
        .clk   (Clock),
        .rst_n (Reset),
        .start (Dump_start),
        .ready (Dump_ready),
        .valid (Dump_valid),
        .addr  (Dump_addr),
        .done  (Dump_done)
    );

endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised successor to the 16x16 register file. It keeps one synchronous write port and two combinational read ports, with configurable width and depth, an optional hard-wired-zero register 0, and optional write-to-read forwarding. A handshaked dump port replaces the per-register flat outputs and streams every register out in address order. It sits in the datapath between the instruction decoder (which drives addresses) and the function unit/bus (which consumes A, B and the dump stream).

## Interface
- DATA_WIDTH, 16: register width in bits.
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_R0, 0: when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 0: when 1, a same-cycle write is forwarded to A/B/Dump_data.

- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- WR  in  1  write enable.
- DA  in  ADDR_WIDTH  write address.
- D  in  DATA_WIDTH  write data.
- AA  in  ADDR_WIDTH  read address, port A.
- BA  in  ADDR_WIDTH  read address, port B.
- A  out  DATA_WIDTH  read data, port A, combinational.
- B  out  DATA_WIDTH  read data, port B, combinational.
- Dump_start  in  1  one-cycle request to begin a dump.
- Dump_ready  in  1  consumer accepts the current dump word.
- Dump_valid  out  1  dump word present.
- Dump_addr  out  ADDR_WIDTH  address of the current dump word.
- Dump_data  out  DATA_WIDTH  contents of register Dump_addr.
- Dump_done  out  1  one-cycle pulse after the last word transfers.

## Operation
- Write: at a rising edge with Reset=1 and WR=1, reg[DA] <= D. With ZERO_R0=1 and DA=0 the write is dropped.
- Read: A = reg[AA] and B = reg[BA] combinationally. With ZERO_R0=1, address 0 reads 0.
- Forwarding (BYPASS=1): if WR=1 and AA==DA (and the write is not dropped), A = D; the same rule applies to B and Dump_data. With BYPASS=0, reads return the pre-write value until the next cycle.
- Dump FSM states:
  - IDLE: Dump_valid=0. Dump_start=1 moves to SCAN with index 0.
  - SCAN: Dump_valid=1, Dump_addr=index, Dump_data read through the same read path as A/B.
    - Transfer occurs on Dump_valid && Dump_ready.
    - Transfer with index < DEPTH-1: index increments.
    - Transfer with index = DEPTH-1: go to IDLE and pulse Dump_done for one cycle. The index returns to 0; there is no wrap-around into a second pass.
- Dump_start while in SCAN is ignored; it neither restarts the dump nor is queued.
- Writes during a dump are legal. A word not yet transferred shows its latest value.
- Dump_ready=0 holds index, Dump_addr and Dump_data stable, except when a concurrent write changes the addressed register.

## Timing
- Reset (Reset=0 at an edge): all registers become 0, FSM goes to IDLE, index becomes 0, Dump_valid=0, Dump_done=0. A and B then read 0.
- Reset takes priority over WR and Dump_start in the same cycle. Reset during SCAN aborts the dump with no Dump_done.
- Write latency: 1 edge. Read latency: 0 (combinational).
- Dump: Dump_valid rises the cycle after Dump_start. With Dump_ready held high, a full dump takes DEPTH cycles. Dump_done is asserted in the cycle after the final transfer, while Dump_valid=0.
- Dump_start in the same cycle as Dump_done: the block is in IDLE, so a new dump starts.

## Structure
- Package register_file_pkg holds the FSM state type {IDLE, SCAN} and default parameter constants.
- Sub-module register_file_dump_fsm holds the state, index and Dump_done logic and outputs Dump_addr. The top level holds the storage array, the three read muxes and the forwarding logic.

## Test plan
- Reset then read: after Reset=0 for one edge, AA=5, BA=15 -> A=0x0000, B=0x0000, Dump_valid=0.
- Write/read all: write reg[i]=0x1000+i for i=0..15, then sweep AA=i, BA=15-i -> A=0x1000+i, B=0x100F-i.
- ZERO_R0=1: WR=1, DA=0, D=0xBEEF, then AA=0 -> A=0x0000. Repeat with ZERO_R0=0 -> A=0xBEEF.
- BYPASS=1: reg[3]=0x1111, then WR=1, DA=3, D=0x2222, AA=3 in the same cycle -> A=0x2222 immediately. With BYPASS=0 -> A=0x1111, then 0x2222 after the edge.
- Dump with backpressure: load reg[i]=i*3, pulse Dump_start, drive Dump_ready=0 on every third cycle -> 16 transfers in order with Dump_addr 0..15 and Dump_data 0,3,..,45, stable while stalled. Dump_done pulses exactly once, one cycle after the last transfer. A second Dump_start mid-scan has no effect.
- Reset mid-dump: assert Reset=0 at Dump_addr=7 -> next cycle Dump_valid=0, no Dump_done, all registers 0. A new Dump_start yields 16 zero words.
